// File: rtl/minisys_pkg.sv
// Shared definitions for the Minisys-1A MEM stage.
//   - access-size encodings carried on mem_sizeM
//   - MEM-stage FSM states
//   - MEM/WB pipeline register layout
//   - alignment helper used by the stage
package minisys_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;  // 2'b11 behaves as word

  localparam int CNT_W = 8;  // wait-state counter width

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] read_data;
    logic [31:0] pcplus4;
    logic [4:0]  write_reg;
    logic        mem2reg;
    logic        reg_write;
    logic        write_31;
    logic        adel;
    logic        ades;
    logic        bus_err;
  } wb_t;

  // Byte accesses never fault; halves need an even address; words (and
  // the reserved size) need a 4-byte aligned address.
  function automatic logic misaligned(logic [1:0] size, logic [1:0] a);
    case (size)
      MEM_BYTE: misaligned = 1'b0;
      MEM_HALF: misaligned = a[0];
      default:  misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/minisys_mem_stage_if.sv
// Data-memory request/acknowledge bus.
//   req/we/addr/be/wdata : stage -> memory
//   rdata/ack            : memory -> stage
interface minisys_mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/minisys_load_align.sv
// Load formatter: picks the byte/halfword lane addressed by addr_lo out of
// the little-endian word rdata and sign- or zero-extends it to 32 bits.
//   rdata    : raw memory word
//   addr_lo  : byte offset within the word
//   size     : MEM_BYTE / MEM_HALF / word
//   uns      : zero-extend instead of sign-extend
//   data     : formatted result
module minisys_load_align
  import minisys_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MEM_BYTE: data = {{24{byte_sel[7] & ~uns}}, byte_sel};
      MEM_HALF: data = {{16{half_sel[15] & ~uns}}, half_sel};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/minisys_mem_stage.sv
// Minisys-1A MEM stage with the MEM/WB register folded in.
//   clk, rst         : clock, synchronous active-high reset
//   *M inputs        : EX/MEM register contents
//   dm               : data-memory req/ack bus (master side)
//   stallM           : freezes PC, IF/ID, ID/EX, EX/MEM while memory is busy
//   *W outputs       : MEM/WB register, incl. one-shot exception flags
module minisys_mem_stage
  import minisys_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit ALIGN_CHECK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validM,
  input  logic        mem2regM,
  input  logic        mem_writeM,
  input  logic        reg_writeM,
  input  logic        write_31M,
  input  logic [1:0]  mem_sizeM,
  input  logic        mem_unsignedM,
  input  logic [31:0] alu_outM,
  input  logic [31:0] write_dataM,
  input  logic [31:0] pcplus4M,
  input  logic [4:0]  write_regM,
  minisys_mem_stage_if.master dm,
  output logic        stallM,
  output logic [31:0] alu_outW,
  output logic [31:0] read_dataW,
  output logic [31:0] pcplus4W,
  output logic [4:0]  write_regW,
  output logic        mem2regW,
  output logic        reg_writeW,
  output logic        write_31W,
  output logic        adelW,
  output logic        adesW,
  output logic        bus_errW
);

  // The counter holds how many cycles the request has already been
  // outstanding, so the abort lands on the TIMEOUT_CYCLES-th request cycle.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wb_t              wb_q, wb_d;

  logic        mem_op, mis, req, abort, exc;
  logic [3:0]  be;
  logic [31:0] wdata, load_data;

  minisys_load_align u_align (
    .rdata   (dm.rdata),
    .addr_lo (alu_outM[1:0]),
    .size    (mem_sizeM),
    .uns     (mem_unsignedM),
    .data    (load_data)
  );

  // Inputs stay frozen by the stall while BUSY, so bus fields can be
  // driven straight from the M-side signals and remain stable.
  always_comb begin
    mem_op = validM & (mem2regM | mem_writeM);
    mis    = ALIGN_CHECK & mem_op & misaligned(mem_sizeM, alu_outM[1:0]);
    req    = ~rst & ((state_q == IDLE & mem_op & ~mis) | state_q == BUSY);
    abort  = req & ~dm.ack & (cnt_q == TO_LAST);
    stallM = req & ~dm.ack & (cnt_q != TO_LAST);
    exc    = mis | abort;
  end

  always_comb begin
    be    = 4'b1111;
    wdata = write_dataM;
    if (mem_writeM) begin
      case (mem_sizeM)
        MEM_BYTE: begin
          be    = 4'b0001 << alu_outM[1:0];
          wdata = {4{write_dataM[7:0]}};
        end
        MEM_HALF: begin
          be    = alu_outM[1] ? 4'b1100 : 4'b0011;
          wdata = {2{write_dataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign dm.req   = req;
  assign dm.we    = req & mem_writeM;
  assign dm.addr  = {alu_outM[31:2], 2'b00};
  assign dm.be    = be;
  assign dm.wdata = wdata;

  always_comb begin
    state_d = stallM ? BUSY : IDLE;
    cnt_d   = stallM ? cnt_q + 1'b1 : '0;
  end

  // Bubbles clear only the controls; data fields keep their old value.
  always_comb begin
    wb_d           = wb_q;
    wb_d.mem2reg   = 1'b0;
    wb_d.reg_write = 1'b0;
    wb_d.write_31  = 1'b0;
    wb_d.adel      = 1'b0;
    wb_d.ades      = 1'b0;
    wb_d.bus_err   = 1'b0;
    if (validM & ~stallM) begin
      wb_d.alu_out   = alu_outM;
      wb_d.read_data = load_data;
      wb_d.pcplus4   = pcplus4M;
      wb_d.write_reg = write_regM;
      wb_d.mem2reg   = mem2regM & ~exc;
      wb_d.reg_write = reg_writeM & ~exc;
      wb_d.write_31  = write_31M & ~exc;
      wb_d.adel      = mis & mem2regM;
      wb_d.ades      = mis & mem_writeM;
      wb_d.bus_err   = abort;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
    end
  end

  assign alu_outW   = wb_q.alu_out;
  assign read_dataW = wb_q.read_data;
  assign pcplus4W   = wb_q.pcplus4;
  assign write_regW = wb_q.write_reg;
  assign mem2regW   = wb_q.mem2reg;
  assign reg_writeW = wb_q.reg_write;
  assign write_31W  = wb_q.write_31;
  assign adelW      = wb_q.adel;
  assign adesW      = wb_q.ades;
  assign bus_errW   = wb_q.bus_err;

endmodule
